// File: rtl/byte_stream_packer.sv
// Packs a byte-wide valid/ready stream into OUT_BYTES-wide words with keep mask and packet count.
// Define BYTE_STREAM_PACKER_BIG_ENDIAN_EN to place the first byte of a word in the MSB lane.
module byte_stream_packer #(
    parameter int OUT_BYTES = 8,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [8*OUT_BYTES-1:0]       out_data,
    output logic [OUT_BYTES-1:0]         out_keep,
    output logic [$clog2(OUT_BYTES):0]   out_nbytes,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             pkt_count
);

    localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int NB_W  = $clog2(OUT_BYTES) + 1;

    logic [OUT_BYTES-1:0][7:0] acc_reg;
    logic [OUT_BYTES-1:0][7:0] acc_next;
    logic [IDX_W-1:0]          idx_reg;
    logic [8*OUT_BYTES-1:0]    data_reg;
    logic [OUT_BYTES-1:0]      keep_reg;
    logic [OUT_BYTES-1:0]      keep_next;
    logic [NB_W-1:0]           nbytes_reg;
    logic                      last_reg;
    logic                      valid_reg;
    logic [CNT_W-1:0]          cnt_reg;

    logic accept;
    logic complete;
    logic drain;

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (idx_reg == IDX_W'(OUT_BYTES - 1)));
    assign drain    = valid_reg && out_ready;

    // Each lane knows which byte position of the word it holds; keep is
    // simply "position already filled", which keeps the mask contiguous.
    generate
        for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
`ifdef BYTE_STREAM_PACKER_BIG_ENDIAN_EN
            localparam int LANE_POS = OUT_BYTES - 1 - gi;
`else
            localparam int LANE_POS = gi;
`endif
            assign acc_next[gi]  = (accept && (idx_reg == IDX_W'(LANE_POS))) ? in_data : acc_reg[gi];
            assign keep_next[gi] = (IDX_W'(LANE_POS) <= idx_reg);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            idx_reg    <= '0;
            data_reg   <= '0;
            keep_reg   <= '0;
            nbytes_reg <= '0;
            last_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (complete) begin
                // New word replaces the draining one on the same edge.
                data_reg   <= acc_next;
                keep_reg   <= keep_next;
                nbytes_reg <= NB_W'(idx_reg) + NB_W'(1);
                last_reg   <= in_last;
                valid_reg  <= 1'b1;
                acc_reg    <= '0;
                idx_reg    <= '0;
            end else begin
                if (accept) begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                if (drain) begin
                    valid_reg <= 1'b0;
                end
            end
            if (drain && last_reg && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_data   = data_reg;
    assign out_keep   = keep_reg;
    assign out_nbytes = nbytes_reg;
    assign out_last   = last_reg;
    assign out_valid  = valid_reg;
    assign pkt_count  = cnt_reg;

endmodule
